// File: rtl/detect_sequence_serializer.sv
// rtl/detect_sequence_serializer.sv - word-to-bit serializer feeding a downstream sequence detector
module detect_sequence_serializer #(
    parameter int   W        = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_bit,
    output logic         out_valid,
    output logic         out_first,
    output logic         out_last,
    output logic         gap,
    output logic [15:0]  words_sent
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] MSB_IDX  = CW'(W - 1);
    localparam logic [15:0]   SENT_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  hold_reg;
    logic          hold_full;
    logic [W-1:0]  shift_reg;
    logic [W-1:0]  shift_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          load;
    logic          gap_next;
    logic          accept;

    // The hold register is the only buffer the producer sees, so readiness
    // depends on nothing but its occupancy.
    assign in_ready = ~hold_full;
    assign accept   = in_valid & ~hold_full;

    // State register for the IDLE/SHIFT controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stream decode; outputs look only at registered state.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = cnt;
        load       = 1'b0;
        gap_next   = 1'b0;
        out_bit    = IDLE_BIT;
        out_valid  = 1'b0;
        out_first  = 1'b0;
        out_last   = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    load       = 1'b1;
                    shift_next = hold_reg;
                    cnt_next   = MSB_IDX;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                out_bit   = shift_reg[W-1];
                out_valid = 1'b1;
                out_first = (cnt == MSB_IDX);
                out_last  = (cnt == '0);
                if (cnt != '0) begin
                    shift_next = shift_reg << 1;
                    cnt_next   = cnt - 1'b1;
                end else if (hold_full) begin
                    // Back-to-back reload keeps the bit stream gapless.
                    load       = 1'b1;
                    shift_next = hold_reg;
                    cnt_next   = MSB_IDX;
                end else begin
                    state_next = IDLE;
                    gap_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register, shifter, bit counter and the registered gap pulse.
    // Accept and load are mutually exclusive: accept needs hold empty, load
    // needs it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            cnt       <= '0;
            gap       <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg  <= in_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            shift_reg <= shift_next;
            cnt       <= cnt_next;
            gap       <= gap_next;
        end
    end

    // Completed-word counter, bumped on each LSB and pinned at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_sent <= '0;
        end else if (out_last && (words_sent != SENT_MAX)) begin
            words_sent <= words_sent + 16'd1;
        end
    end

endmodule

// File: tb/tb_detect_sequence_serializer.sv
// tb/tb_detect_sequence_serializer.sv - scoreboard bench for detect_sequence_serializer
module tb_detect_sequence_serializer;

    localparam int   W        = 8;
    localparam logic IDLE_BIT = 1'b0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic         gap;
    logic [15:0]  words_sent;

    detect_sequence_serializer #(.W(W), .IDLE_BIT(IDLE_BIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .out_first  (out_first),
        .out_last   (out_last),
        .gap        (gap),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // expected {bit, first, last} per serial cycle
    logic [2:0] sb[$];

    int first_valid_cyc = -1;
    int last_valid_cyc  = -1;
    int first_one_cyc   = -1;
    int det_cyc         = -1;
    int det_cnt         = 0;
    int gap_cnt         = 0;
    int run             = 0;
    int max_run         = 0;

    logic [5:0] hist;
    logic       detected;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // downstream detector for pattern 110011, registered output
    always @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            detected <= 1'b0;
        end else begin
            detected <= out_valid && ({hist[4:0], out_bit} == 6'b110011);
            if (out_valid) hist <= {hist[4:0], out_bit};
        end
    end

    // output monitor: pops the scoreboard on every data cycle
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("stray_bit", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("out_bit", out_bit, e[2]);
                    check("out_first", out_first, e[1]);
                    check("out_last", out_last, e[0]);
                end
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_last) last_valid_cyc = cyc;
                if (out_bit && first_one_cyc < 0) first_one_cyc = cyc;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
                check("idle_bit", out_bit, IDLE_BIT);
                check("idle_flags", {out_first, out_last}, 2'b00);
            end
            if (gap) gap_cnt++;
            if (detected) begin
                det_cnt++;
                det_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        first_valid_cyc = -1;
        last_valid_cyc  = -1;
        first_one_cyc   = -1;
        det_cyc         = -1;
        det_cnt         = 0;
        gap_cnt         = 0;
        max_run         = 0;
    endtask

    task automatic send_word(input logic [W-1:0] d, output int stalls, output int acc_cyc);
        logic acc;
        logic done;
        stalls = 0;
        done   = 1'b0;
        acc_cyc = -1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            acc      = in_ready;
            acc_cyc  = cyc;
            @(posedge clk);
            if (acc) begin
                done = 1'b1;
                for (int i = W - 1; i >= 0; i--)
                    sb.push_back({d[i], (i == W - 1) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
            end else begin
                stalls++;
            end
        end
        if (!done) check("accept_timeout", done, 1'b1);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic drained;
        drained = 1'b0;
        for (int n = 0; n < 200 && !drained; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid && in_ready) drained = 1'b1;
        end
        check("drain_timeout", drained, 1'b1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        clear_stats();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0, st1, st2, ac;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_bit", out_bit, IDLE_BIT);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_first", out_first, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_gap", gap, 1'b0);
        check("rst_words_sent", words_sent, 16'd0);

        // single word 0xCC: latency, framing, gap, count
        clear_stats();
        send_word(8'hCC, st0, ac);
        drop_valid();
        wait_drain();
        check("cc_stalls", st0, 0);
        check("cc_msb_latency", first_valid_cyc - ac, 2);
        check("cc_lsb_latency", last_valid_cyc - ac, 2 + W - 1);
        check("cc_gap_pulses", gap_cnt, 1);
        check("cc_words_sent", words_sent, 16'd1);

        // 0xA5 then 0x3C back to back: gapless 16 bits, one stall for the held word
        do_reset();
        send_word(8'hA5, st0, ac);
        send_word(8'h3C, st1, ac);
        drop_valid();
        wait_drain();
        check("pair_stall_second", st1, 1);
        check("pair_run_length", max_run, 16);
        check("pair_gap_pulses", gap_cnt, 1);
        check("pair_words_sent", words_sent, 16'd2);

        // third word blocked while the hold register is full
        clear_stats();
        send_word(8'h81, st0, ac);
        send_word(8'h7E, st1, ac);
        send_word(8'h99, st2, ac);
        drop_valid();
        wait_drain();
        check("trip_stall_second", st1, 1);
        check("trip_stall_third", st2, W - 1);
        check("trip_run_length", max_run, 24);
        check("trip_words_sent", words_sent, 16'd5);

        // reset on the 4th bit of 0xFF with 0x00 held
        do_reset();
        send_word(8'hFF, st0, ac);
        send_word(8'h00, st1, ac);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_bit", out_bit, IDLE_BIT);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_words_sent", words_sent, 16'd0);
        rst = 1'b0;
        clear_stats();
        repeat (20) @(negedge clk);
        #1;
        check("mid_rst_no_residue", first_valid_cyc, -1);

        // detector sees 00110011 and fires once, 6 bits after the first 1
        clear_stats();
        send_word(8'b0011_0011, st0, ac);
        drop_valid();
        wait_drain();
        check("det_count", det_cnt, 1);
        check("det_offset", det_cyc - first_one_cyc, 6);

        // saturation from 0xFFFE over three words
        @(negedge clk);
        force dut.words_sent = 16'hFFFE;
        #1;
        release dut.words_sent;
        @(negedge clk);
        #1;
        check("sat_preload", words_sent, 16'hFFFE);
        send_word(8'h11, st0, ac);
        send_word(8'h22, st1, ac);
        send_word(8'h33, st2, ac);
        drop_valid();
        wait_drain();
        check("sat_words_sent", words_sent, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/detect_sequence_serializer.md
DETECT_SEQUENCE_SERIALIZER -- requirements
Module: detect_sequence_serializer

Interface
REQ-001 Parameter W, default 8, word width in bits; the block SHALL support W in the range 2..32.
REQ-002 Parameter IDLE_BIT, default 1'b0, the value driven on out_bit while no word is being shifted.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  producer has a word on in_data.
REQ-006 in_data  input  W  parallel word, transmitted MSB first.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_bit  output  1  serial bit stream, one bit per cycle, feeding the downstream sequence detector's new_bit input.
REQ-009 out_valid  output  1  out_bit carries word data this cycle (0 means idle fill).
REQ-010 out_first  output  1  out_bit is the MSB of a word.
REQ-011 out_last  output  1  out_bit is the LSB of a word.
REQ-012 gap  output  1  one-cycle pulse when the stream falls idle after a word.
REQ-013 words_sent  output  16  count of fully shifted words, saturating.

Function
REQ-014 Storage SHALL be a W-bit holding register with flag hold_full, a W-bit shift register, and a bit counter cnt of width clog2(W).
REQ-015 in_ready SHALL equal ~hold_full, combinationally, with no dependence on in_valid.
REQ-016 A transfer SHALL occur on a clock edge where in_valid & in_ready; in_data SHALL be written to the holding register and hold_full set.
REQ-017 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-018 IDLE, hold_full=0: remain in IDLE; out_bit=IDLE_BIT; out_valid=out_first=out_last=0.
REQ-019 IDLE, hold_full=1: on the next edge move hold->shift, clear hold_full, set cnt=W-1, enter SHIFT.
REQ-020 SHIFT: out_bit=shift[W-1]; out_valid=1; out_first=(cnt==W-1); out_last=(cnt==0); on each edge with cnt!=0, shift left by one and decrement cnt.
REQ-021 SHIFT, cnt==0, hold_full=1: on the next edge reload from hold, clear hold_full, set cnt=W-1, stay in SHIFT; no idle cycle SHALL be inserted.
REQ-022 SHIFT, cnt==0, hold_full=0: on the next edge enter IDLE and assert gap for exactly the following cycle.
REQ-023 Latency: for a word accepted at edge E0 with the block idle, its MSB SHALL appear on out_bit in the cycle after edge E1 (2 edges); its LSB SHALL appear W-1 cycles later.
REQ-024 Simultaneous reload and accept: when hold_full=1, no accept is possible that cycle; a new word SHALL be accepted no earlier than the cycle after hold empties.
REQ-025 words_sent SHALL increment on every edge where out_last=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-026 Outputs out_bit, out_valid, out_first, out_last SHALL be decoded from registered state only, with no combinational path from in_valid/in_data.

Reset
REQ-027 While rst=1 at an edge: state=IDLE, hold_full=0, shift=0, cnt=0, words_sent=0, and gap register=0.
REQ-028 Resulting outputs after reset: in_ready=1, out_bit=IDLE_BIT, out_valid=out_first=out_last=gap=0.
REQ-029 Reset mid-word SHALL discard both the word being shifted and the held word; no partial bits SHALL appear after reset deasserts.

Verification
REQ-030 W=8, a single word 8'hCC sent after reset -> out_bit sequence 1,1,0,0,1,1,0,0 starting 2 edges after acceptance; out_first on bit 1 and out_last on bit 8; gap pulses once; words_sent=1.
REQ-031 Words 8'hA5 then 8'h3C with in_valid held high -> 16 consecutive cycles with out_valid=1 and no idle cycle between the words; in_ready low while hold is full; words_sent=2.
REQ-032 in_valid=1 with in_ready=0 (hold full) -> the word is not captured; the producer holds the word until acceptance; no word is lost or duplicated.
REQ-033 rst asserted at the 4th bit of 8'hFF with 8'h00 held -> the next cycle shows out_valid=0, out_bit=IDLE_BIT, in_ready=1, words_sent=0.
REQ-034 Downstream detector connected; stream 8'b00110011 -> the detector's detected output asserts exactly once, 6 bits after the first 1.
REQ-035 Force words_sent to 16'hFFFE and send 3 words -> count ends at 16'hFFFF and does not wrap.
